// File: rtl/pipeline_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: bus widths and helpers.
package pipeline_skid_stage_pkg;

  // Legacy fixed-field bus widths still referenced by neighbouring stages
  localparam int DATA_BUS_W       = 32;
  localparam int INST_BUS_W       = 32;
  // Default active-list index width; tag bus is derived from it
  localparam int FREE_LIST_W_DEF  = 3;
  localparam int PIPE_TAG_BUS_W   = FREE_LIST_W_DEF;
  // Performance counter width
  localparam int PERF_CNT_W       = 32;

  // Saturating add of a small increment to a perf counter
  function automatic logic [PERF_CNT_W-1:0] sat_add(
    input logic [PERF_CNT_W-1:0] a,
    input logic [1:0]            b
  );
    logic [PERF_CNT_W:0] s;
    s = {1'b0, a} + {{(PERF_CNT_W-1){1'b0}}, b};
    return s[PERF_CNT_W] ? {PERF_CNT_W{1'b1}} : s[PERF_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pipeline_age_cmp.sv
// Modular age compare: flags a tag as younger than the kill tag, with ages
// measured from the active-list head so circular wrap is handled.
module pipeline_age_cmp #(
  parameter int TW = 3
) (
  input  logic [TW-1:0] i_tag,
  input  logic [TW-1:0] i_kill_tag,
  input  logic [TW-1:0] i_head,
  output logic          o_younger
);

  logic [TW-1:0] w_age_tag;
  logic [TW-1:0] w_age_kill;

  // Subtraction truncated to TW bits is the mod-2^TW distance from head
  always_comb begin
    w_age_tag  = i_tag - i_head;
    w_age_kill = i_kill_tag - i_head;
    o_younger  = w_age_tag > w_age_kill;
  end

endmodule

// File: rtl/pipeline_skid_stage.sv
// Parametrised valid/ready pipeline register with a 2-entry skid buffer,
// flush / global flush and tag-based selective kill.
// Optional perf counters enabled by defining PIPELINE_SKID_STAGE_PERF_EN.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int PAYLOAD_WIDTH   = 128,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       global_flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
  input  logic [FREE_LIST_WIDTH-1:0] in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_WIDTH-1:0]   out_payload,
  output logic [FREE_LIST_WIDTH-1:0] out_tag,
  input  logic                       kill_valid,
  input  logic [FREE_LIST_WIDTH-1:0] kill_tag,
  input  logic [FREE_LIST_WIDTH-1:0] kill_head
`ifdef PIPELINE_SKID_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]      perf_stall_cnt,
  output logic [PERF_CNT_W-1:0]      perf_kill_cnt
`endif
);

  localparam int PW = PAYLOAD_WIDTH;
  localparam int TW = FREE_LIST_WIDTH;

  // Stored entries; main drives the outputs directly
  logic          r_main_v, r_skid_v, r_in_ready;
  logic [PW-1:0] r_main_p, r_skid_p;
  logic [TW-1:0] r_main_t, r_skid_t;

  // Next-state values
  logic          w_main_v_n, w_skid_v_n;
  logic [PW-1:0] w_main_p_n, w_skid_p_n;
  logic [TW-1:0] w_main_t_n, w_skid_t_n;

  logic w_in_xfer, w_out_xfer, w_flush;
  logic w_y_main, w_y_skid, w_y_in;
  logic w_keep_main, w_keep_skid, w_keep_in;
  logic [1:0] w_kill_n;

  assign w_flush    = flush | global_flush;
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_main_v & out_ready;

  pipeline_age_cmp #(.TW(TW)) u_age_main (
    .i_tag(r_main_t), .i_kill_tag(kill_tag), .i_head(kill_head), .o_younger(w_y_main));
  pipeline_age_cmp #(.TW(TW)) u_age_skid (
    .i_tag(r_skid_t), .i_kill_tag(kill_tag), .i_head(kill_head), .o_younger(w_y_skid));
  pipeline_age_cmp #(.TW(TW)) u_age_in (
    .i_tag(in_tag),   .i_kill_tag(kill_tag), .i_head(kill_head), .o_younger(w_y_in));

  // Entries that remain after this edge, oldest first: held main, skid, incoming.
  // A main entry leaving through an output transfer is complete, never killed.
  assign w_keep_main = r_main_v & ~w_out_xfer & ~(kill_valid & w_y_main);
  assign w_keep_skid = r_skid_v & ~(kill_valid & w_y_skid);
  assign w_keep_in   = w_in_xfer & ~(kill_valid & w_y_in);

  // Pack surviving entries into main then skid; this covers the normal
  // advance cases and post-kill compaction alike. Empty slots read zero.
  always_comb begin
    w_main_v_n = 1'b0;
    w_main_p_n = '0;
    w_main_t_n = '0;
    w_skid_v_n = 1'b0;
    w_skid_p_n = '0;
    w_skid_t_n = '0;
    if (!w_flush) begin
      if (w_keep_main) begin
        w_main_v_n = 1'b1;
        w_main_p_n = r_main_p;
        w_main_t_n = r_main_t;
        if (w_keep_skid) begin
          w_skid_v_n = 1'b1;
          w_skid_p_n = r_skid_p;
          w_skid_t_n = r_skid_t;
        end else if (w_keep_in) begin
          w_skid_v_n = 1'b1;
          w_skid_p_n = in_payload;
          w_skid_t_n = in_tag;
        end
      end else if (w_keep_skid) begin
        w_main_v_n = 1'b1;
        w_main_p_n = r_skid_p;
        w_main_t_n = r_skid_t;
        if (w_keep_in) begin
          w_skid_v_n = 1'b1;
          w_skid_p_n = in_payload;
          w_skid_t_n = in_tag;
        end
      end else if (w_keep_in) begin
        w_main_v_n = 1'b1;
        w_main_p_n = in_payload;
        w_main_t_n = in_tag;
      end
    end
  end

  // Number of entries dropped by a kill this cycle; flush takes precedence
  always_comb begin
    w_kill_n = 2'd0;
    if (!w_flush && kill_valid) begin
      w_kill_n = 2'({1'b0, r_main_v & ~w_out_xfer & w_y_main})
               + 2'({1'b0, r_skid_v & w_y_skid})
               + 2'({1'b0, w_in_xfer & w_y_in});
    end
  end

  // Entry state registers; in_ready is the registered complement of skid full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v   <= 1'b0;
      r_main_p   <= '0;
      r_main_t   <= '0;
      r_skid_v   <= 1'b0;
      r_skid_p   <= '0;
      r_skid_t   <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_main_v   <= w_main_v_n;
      r_main_p   <= w_main_p_n;
      r_main_t   <= w_main_t_n;
      r_skid_v   <= w_skid_v_n;
      r_skid_p   <= w_skid_p_n;
      r_skid_t   <= w_skid_t_n;
      r_in_ready <= ~w_skid_v_n;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_v;
  assign out_payload = r_main_p;
  assign out_tag     = r_main_t;

`ifdef PIPELINE_SKID_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt, r_kill_cnt;

  // Saturating stall and kill event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      r_stall_cnt <= sat_add(r_stall_cnt, {1'b0, r_main_v & ~out_ready});
      r_kill_cnt  <= sat_add(r_kill_cnt, w_kill_n);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_kill_cnt  = r_kill_cnt;
`else
  logic w_unused;
  assign w_unused = ^w_kill_n;
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Scoreboard bench for pipeline_skid_stage: directed stimulus pushes
// expected outputs; a negedge monitor pops and compares on each output transfer.
module tb_pipeline_skid_stage;

  localparam int PW = 128;
  localparam int TW = 3;

  typedef struct {
    logic [PW-1:0] p;
    logic [TW-1:0] t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, global_flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_payload, out_payload;
  logic [TW-1:0] in_tag, out_tag, kill_tag, kill_head;
  logic          kill_valid;
`ifdef PIPELINE_SKID_STAGE_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_kill_cnt;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipeline_skid_stage #(.PAYLOAD_WIDTH(PW), .FREE_LIST_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .global_flush(global_flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_tag(out_tag),
    .kill_valid(kill_valid), .kill_tag(kill_tag), .kill_head(kill_head)
`ifdef PIPELINE_SKID_STAGE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  function automatic logic [PW-1:0] pay(input logic [TW-1:0] t);
    logic [31:0] w;
    w = 32'hCAFE_0000 | 32'(t);
    return {w ^ 32'h1, w, ~w, w};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] t, input logic ordy);
    in_valid   = v;
    in_tag     = v ? t : '0;
    in_payload = v ? pay(t) : '0;
    out_ready  = ordy;
  endtask

  task automatic expect_out(input logic [TW-1:0] t);
    exp_t e;
    e.p = pay(t);
    e.t = t;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: compare each output transfer with the scoreboard; check bubbles read zero
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: got tag %0d payload %h expected no output", out_tag, out_payload);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_tag", PW'(out_tag), PW'(e.t));
          check("sb_payload", out_payload, e.p);
        end
      end else if (!out_valid) begin
        check("bubble_zero", {out_payload[PW-1:TW], out_payload[TW-1:0] | out_tag}, '0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; global_flush = 1'b0; kill_valid = 1'b0;
    kill_tag = '0; kill_head = '0;
    drive(1'b0, '0, 1'b0);
    #12;
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_out_payload", out_payload, '0);
    check("rst_in_ready", PW'(in_ready), PW'(1'b1));
    rst_n = 1'b1;

    // Streaming tags 0..7 with no backpressure: one per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      step(); drive(1'b1, TW'(i), 1'b1); expect_out(TW'(i));
      mid();
      if (i > 0) begin
        check("stream_valid", PW'(out_valid), PW'(1'b1));
        check("stream_tag", PW'(out_tag), PW'(i - 1));
      end
    end
    step(); drive(1'b0, '0, 1'b1); mid();
    check("stream_last_tag", PW'(out_tag), PW'(7));
    step(); mid();
    check("stream_empty", PW'(out_valid), '0);

    // Backpressure: A held in main, B in skid, in_ready drops
    step(); drive(1'b1, 3'd1, 1'b0); expect_out(3'd1); mid();
    step(); drive(1'b1, 3'd2, 1'b0); expect_out(3'd2); mid();
    check("bp_rdy_before_b", PW'(in_ready), PW'(1'b1));
    step(); drive(1'b0, '0, 1'b0); mid();
    check("bp_rdy_low", PW'(in_ready), '0);
    check("bp_hold_tag", PW'(out_tag), PW'(1));
    step(); out_ready = 1'b1; mid();
    check("bp_a_out", PW'(out_tag), PW'(1));
    step(); mid();
    check("bp_b_out", PW'(out_tag), PW'(2));
    check("bp_rdy_back", PW'(in_ready), PW'(1'b1));
    step(); mid();
    check("bp_drained", PW'(out_valid), '0);

    // Flush with both entries full and a new input offered
    step(); drive(1'b1, 3'd3, 1'b0); mid();
    step(); drive(1'b1, 3'd4, 1'b0); mid();
    step(); drive(1'b1, 3'd5, 1'b0); flush = 1'b1; mid();
    check("fl_rdy_full", PW'(in_ready), '0);
    step(); drive(1'b0, '0, 1'b1); flush = 1'b0; mid();
    check("fl_out_valid", PW'(out_valid), '0);
    check("fl_out_payload", out_payload, '0);
    check("fl_in_ready", PW'(in_ready), PW'(1'b1));
    step(); step(); mid();

    // Wrapped kill: head 6, kill 7; main tag 0 is younger, skid tag 7 survives
    step(); drive(1'b1, 3'd0, 1'b0); mid();
    step(); drive(1'b1, 3'd7, 1'b0); mid();
    step(); drive(1'b0, '0, 1'b0);
    kill_valid = 1'b1; kill_head = 3'd6; kill_tag = 3'd7; expect_out(3'd7); mid();
    step(); kill_valid = 1'b0; mid();
    check("kill_valid_out", PW'(out_valid), PW'(1'b1));
    check("kill_survivor_tag", PW'(out_tag), PW'(7));
    check("kill_rdy", PW'(in_ready), PW'(1'b1));
`ifdef PIPELINE_SKID_STAGE_PERF_EN
    check("perf_kill_1", PW'(perf_kill_cnt), PW'(1));
`endif
    step(); out_ready = 1'b1; mid();
    step(); mid();
    check("kill_drained", PW'(out_valid), '0);

    // Kill drops an incoming younger entry
    step(); drive(1'b1, 3'd3, 1'b1);
    kill_valid = 1'b1; kill_head = 3'd2; kill_tag = 3'd2; mid();
    step(); drive(1'b0, '0, 1'b1); kill_valid = 1'b0; mid();
    check("kill_in_dropped", PW'(out_valid), '0);
`ifdef PIPELINE_SKID_STAGE_PERF_EN
    check("perf_kill_2", PW'(perf_kill_cnt), PW'(2));
`endif

    // Entry whose tag equals kill_tag is never killed
    step(); drive(1'b1, 3'd2, 1'b1);
    kill_valid = 1'b1; kill_head = 3'd2; kill_tag = 3'd2; expect_out(3'd2); mid();
    step(); drive(1'b0, '0, 1'b1); kill_valid = 1'b0; mid();
    check("kill_eq_survives", PW'(out_tag), PW'(2));
    check("kill_eq_valid", PW'(out_valid), PW'(1'b1));
    step(); mid();

    // Kill and flush together: flush wins, kill counter unchanged
    step(); drive(1'b1, 3'd1, 1'b0); mid();
    step(); drive(1'b1, 3'd2, 1'b0); mid();
    step(); drive(1'b0, '0, 1'b0);
    kill_valid = 1'b1; kill_head = 3'd0; kill_tag = 3'd0; flush = 1'b1; mid();
    step(); kill_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; mid();
    check("kf_out_valid", PW'(out_valid), '0);
    check("kf_in_ready", PW'(in_ready), PW'(1'b1));
`ifdef PIPELINE_SKID_STAGE_PERF_EN
    check("perf_kill_kf", PW'(perf_kill_cnt), PW'(2));
`endif

    // Async reset mid-stream with both entries full
    step(); drive(1'b1, 3'd4, 1'b0); mid();
    step(); drive(1'b1, 3'd5, 1'b0); mid();
    step(); drive(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", PW'(out_valid), '0);
    check("arst_out_payload", out_payload, '0);
    check("arst_out_tag", PW'(out_tag), '0);
    check("arst_in_ready", PW'(in_ready), PW'(1'b1));
`ifdef PIPELINE_SKID_STAGE_PERF_EN
    check("arst_perf_kill", PW'(perf_kill_cnt), '0);
`endif
    mid(); rst_n = 1'b1;
    step(); drive(1'b1, 3'd6, 1'b1); expect_out(3'd6); mid();
    check("post_rst_not_yet", PW'(out_valid), '0);
    step(); drive(1'b0, '0, 1'b1); mid();
    check("post_rst_valid", PW'(out_valid), PW'(1'b1));
    check("post_rst_tag", PW'(out_tag), PW'(6));

    step(); step(); mid();
    check("sb_empty", PW'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
